// File: rtl/sync_2ff.sv
`timescale 1ns/100ps
// sync_2ff
// Two-flop synchronizer that brings an asynchronous 1-bit signal into the
// clk domain. The first flop may go metastable; the second flop gives that
// a full clock period to resolve before anything downstream looks at it.
// Reusable by any input stage that needs a hardened copy of a raw pin.
//
// Ports:
//   clk  - system clock, both flops update on its rising edge
//   rst  - asynchronous active-low reset, clears both flops to 0
//   d    - raw asynchronous input
//   q    - synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic metaQ;
    logic syncQ;

    // Shift the raw input through two flops. Only the second stage is
    // exported so consumers never see the possibly-metastable first stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            metaQ <= 1'b0;
            syncQ <= 1'b0;
        end else begin
            metaQ <= d;
            syncQ <= metaQ;
        end
    end

    assign q = syncQ;

endmodule

// File: rtl/debounce_edge_detector.sv
`timescale 1ns/100ps
// debounce_edge_detector
// Turns a bouncing push-button or switch input into a clean, clock-synchronous
// level plus single-cycle rise/fall strobes. The raw input is first hardened
// by a two-flop synchronizer; the synchronized value must then disagree with
// the current debounced level for STABLE_CYCLES consecutive edges before the
// level is allowed to change. Any reversal inside that window restarts it.
//
// Parameters:
//   STABLE_CYCLES - consecutive disagreeing edges needed to update dout (2..65535)
//   CNT_WIDTH     - stability counter width, must hold STABLE_CYCLES-1
//
// Ports:
//   clk  - system clock, all state updates on its rising edge
//   rst  - asynchronous active-low reset, clears all state
//   din  - raw asynchronous input
//   dout - debounced, synchronized level (registered)
//   rise - one-cycle pulse when dout goes 0->1 (registered)
//   fall - one-cycle pulse when dout goes 1->0 (registered)
//   busy - high while the stability counter is non-zero
module debounce_edge_detector #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Reject parameter sets the counter cannot represent, at elaboration time.
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 ||
        ((STABLE_CYCLES - 1) >> CNT_WIDTH) != 0) begin : g_param_check
        $fatal(1, "debounce_edge_detector: illegal STABLE_CYCLES/CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 syncDin;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 dout_q, dout_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (syncDin)
    );

    // Next-state logic for the stability window. Agreement with the current
    // level clears the window, so a glitch shorter than the window leaves no
    // trace. The level only flips on the edge where the counter has already
    // seen STABLE_CYCLES-1 disagreeing edges; that same edge fires the strobe
    // matching the new level. The >= compare keeps the counter bounded even
    // if it were ever upset into an unreachable value.
    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (syncDin == dout_q) begin
            count_d = '0;
        end else if (count_q >= LAST_COUNT) begin
            count_d = '0;
            dout_d  = syncDin;
            rise_d  = syncDin;
            fall_d  = ~syncDin;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // State registers. Reset discards any partially counted window so a
    // full latency applies again after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (count_q != '0);

endmodule

// File: tb/tb_debounce_edge_detector.sv
`timescale 1ns/100ps
// tb_debounce_edge_detector
// Directed bench for debounce_edge_detector with STABLE_CYCLES=4 and a 10 ns
// clock. Expected outputs are packed as {dout, rise, fall, busy}.
module tb_debounce_edge_detector;

    logic clk;
    logic rst;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    int checkCount;
    int errorCount;
    int riseCount;
    int fallCount;
    logic monitorEn;

    typedef struct {
        string      name;
        logic       din;
        logic [3:0] expected;
    } vec_t;

    vec_t vecs[$];

    debounce_edge_detector #(
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // Free-running 10 ns clock; rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count strobes seen while the bounce scenario is active.
    always @(negedge clk) begin
        if (monitorEn) begin
            if (rise) riseCount = riseCount + 1;
            if (fall) fallCount = fallCount + 1;
        end
    end

    task automatic addVec(input string name, input logic dinVal, input logic [3:0] expected);
        vec_t v;
        v.name     = name;
        v.din      = dinVal;
        v.expected = expected;
        vecs.push_back(v);
    endtask

    // Called at a falling edge: drive din, let one rising edge happen, and
    // return at the following falling edge where outputs are stable.
    task automatic applyStimulus(input logic dinVal);
        din = dinVal;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expected, input logic [3:0] mask);
        logic [3:0] actual;
        actual = {dout, rise, fall, busy};
        checkCount = checkCount + 1;
        if ((actual & mask) !== (expected & mask)) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got {dout,rise,fall,busy}=%b, expected %b (mask %b)",
                     name, actual, expected, mask);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount = checkCount + 1;
        if (actual != expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Output pattern k edges after din goes 0->1 from a settled dout=0.
    function automatic logic [3:0] riseSeq(input int k);
        if (k <= 2)      return 4'b0000;
        else if (k <= 5) return 4'b0001;
        else if (k == 6) return 4'b1100;
        else             return 4'b1000;
    endfunction

    // Output pattern k edges after din goes 1->0 from a settled dout=1.
    function automatic logic [3:0] fallSeq(input int k);
        if (k <= 2)      return 4'b1000;
        else if (k <= 5) return 4'b1001;
        else if (k == 6) return 4'b0010;
        else             return 4'b0000;
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        riseCount  = 0;
        fallCount  = 0;
        monitorEn  = 1'b0;
        rst        = 1'b0;
        din        = 1'b1;

        // Table: idle, clean rise, clean fall, then a 3-edge glitch.
        addVec("idle1", 1'b0, 4'b0000);
        addVec("idle2", 1'b0, 4'b0000);
        for (int k = 1; k <= 10; k++) addVec($sformatf("rise_e%0d", k), 1'b1, riseSeq(k));
        for (int k = 1; k <= 8; k++)  addVec($sformatf("fall_e%0d", k), 1'b0, fallSeq(k));
        addVec("glitch_e1", 1'b1, 4'b0000);
        addVec("glitch_e2", 1'b1, 4'b0000);
        addVec("glitch_e3", 1'b1, 4'b0001);
        addVec("glitch_e4", 1'b0, 4'b0001);
        addVec("glitch_e5", 1'b0, 4'b0001);
        addVec("glitch_e6", 1'b0, 4'b0000);
        addVec("glitch_e7", 1'b0, 4'b0000);
        addVec("glitch_e8", 1'b0, 4'b0000);

        // Held in reset with din=1 and the clock running: nothing may move.
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", 4'b0000, 4'b1111);

        // din=1 at release is an ordinary 0->1 transition.
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("release_high_e%0d", k), riseSeq(k), 4'b1111);
        end

        // Asynchronous reset between edges clears dout without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_immediate", 4'b0000, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        checkOutput("async_reset_held", 4'b0000, 4'b1111);
        din = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].din);
            checkOutput(vecs[i].name, vecs[i].expected, 4'b1111);
        end

        // Reset mid-window: four edges into a rise, then reset for two cycles.
        for (int k = 1; k <= 4; k++) applyStimulus(1'b1);
        checkOutput("midwin_before_reset", 4'b0001, 4'b1111);
        rst = 1'b0;
        #1;
        checkOutput("midwin_reset_immediate", 4'b0000, 4'b1111);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("midwin_release_e%0d", k), riseSeq(k), 4'b1111);
        end
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("midwin_fall_e%0d", k), fallSeq(k), 4'b1111);
        end

        // Bounce: toggle every 7 ns for ~100 ns (offset 0.5 ns so no toggle
        // lands on a clock edge), then settle high. busy is masked after the
        // settle because the window state left by the bouncing is uncertain
        // for the first edge.
        #0.5;
        riseCount = 0;
        fallCount = 0;
        monitorEn = 1'b1;
        repeat (14) #7 din = ~din;
        #7 din = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bounce_settle_e%0d", k), riseSeq(k), 4'b1110);
        end
        repeat (3) @(negedge clk);
        monitorEn = 1'b0;
        checkValue("bounce_rise_pulses", riseCount, 1);
        checkValue("bounce_fall_pulses", fallCount, 0);
        checkOutput("bounce_final", 4'b1000, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
